window_loader: RTL and testbench



---
 rtl/window_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_window_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_loader.sv
// window_loader: writer side of the window-register pair read by convolveX.
// On a request it reads two KERNEL_SIZE x KERNEL_SIZE pixel windows from the
// image BRAM (1-cycle read latency) and writes them row-major into
// window1_reg / window2_reg. Window2 sits STRIDE columns right of window1.
// The two windows are fetched interleaved: even issue slots feed window1,
// odd slots feed window2, so both registers fill in 2*K*K issue cycles.
//
// Request handshake: i_start is a one-cycle request that is only sampled
// while o_busy is low. A request seen while busy is dropped, not queued.
// Each accepted request ends with exactly one o_done pulse. A rejected
// request ends with exactly one o_err pulse.
//
// Build option: define WINDOW_LOADER_ZERO_PAD_EN to skip the range check.
// Pixels outside the image are then written as 0 without touching the BRAM.
module window_loader #(
    parameter int KERNEL_SIZE     = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int IMG_W           = 28,
    parameter int IMG_H           = 28,
    parameter int STRIDE          = 1,
    parameter int COORD_WIDTH     = 5,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int ADDR_SIZE       = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [COORD_WIDTH-1:0]     i_row,
    input  logic [COORD_WIDTH-1:0]     i_col,
    output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
    input  logic [DATA_WIDTH-1:0]      i_bram_data,
    output logic                       o_wr_en1,
    output logic                       o_wr_en2,
    output logic [ADDR_SIZE-1:0]       o_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_wr_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);
    // One extra address bit, so an overflowing sum is detected instead of wrapping.
    localparam int AW = BRAM_ADDR_WIDTH + 1;
    // Pixel coordinate width: the origin plus the largest in-window offset.
    localparam int PW = COORD_WIDTH + $clog2(KERNEL_SIZE + STRIDE + 1) + 1;
    localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [COORD_WIDTH-1:0]     row_q, row_d, col_q, col_d;
    logic [KW-1:0]              kr_q, kr_d, kc_q, kc_d;
    logic                       odd_q, odd_d;
    logic [ADDR_SIZE-1:0]       e_q, e_d;
    logic [AW-1:0]              base_q, base_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       issue_pad_q, issue_pad_d;
    logic                       wr_en1_q, wr_en1_d, wr_en2_q, wr_en2_d;
    logic [ADDR_SIZE-1:0]       wr_addr_q, wr_addr_d;
    logic                       wr_pad_q, wr_pad_d;

    // The pixel that will be issued in the following cycle.
    logic [COORD_WIDTH-1:0] org_row, org_col;
    logic [KW-1:0]          nxt_kr, nxt_kc;
    logic                   nxt_odd;
    logic [ADDR_SIZE-1:0]   nxt_e;
    logic [AW-1:0]          nxt_base, nxt_addr;
    logic [PW-1:0]          nxt_coff, nxt_prow, nxt_pcol;
    logic                   nxt_oor;
    logic                   req_ok, last_issue, load_next;

`ifdef WINDOW_LOADER_ZERO_PAD_EN
    assign req_ok = 1'b1;
`else
    // The whole of both windows must lie inside the image.
    assign req_ok = ((PW'(i_row) + PW'(KERNEL_SIZE - 1)) < PW'(IMG_H)) &&
                    ((PW'(i_col) + PW'(STRIDE + KERNEL_SIZE - 1)) < PW'(IMG_W));
`endif

    assign last_issue = odd_q && (kr_q == KW'(KERNEL_SIZE - 1)) &&
                        (kc_q == KW'(KERNEL_SIZE - 1));

    // Step to the next pixel. The row base moves by IMG_W once per window row.
    // The origin offset is a constant-coefficient product, formed only once per request.
    always_comb begin
        org_row  = row_q;
        org_col  = col_q;
        nxt_kr   = kr_q;
        nxt_kc   = kc_q;
        nxt_odd  = ~odd_q;
        nxt_e    = e_q;
        nxt_base = base_q;
        if (state_q == S_IDLE) begin
            org_row  = i_row;
            org_col  = i_col;
            nxt_kr   = '0;
            nxt_kc   = '0;
            nxt_odd  = 1'b0;
            nxt_e    = '0;
            nxt_base = AW'(i_row) * AW'(IMG_W) + AW'(i_col);
        end else if (odd_q) begin
            nxt_e = e_q + ADDR_SIZE'(1);
            if (kc_q == KW'(KERNEL_SIZE - 1)) begin
                nxt_kc   = '0;
                nxt_kr   = kr_q + KW'(1);
                nxt_base = base_q + AW'(IMG_W);
            end else begin
                nxt_kc = kc_q + KW'(1);
            end
        end
        nxt_coff = PW'(nxt_kc) + (nxt_odd ? PW'(STRIDE) : '0);
        nxt_prow = PW'(org_row) + PW'(nxt_kr);
        nxt_pcol = PW'(org_col) + nxt_coff;
        nxt_addr = nxt_base + AW'(nxt_coff);
        nxt_oor  = (nxt_prow >= PW'(IMG_H)) || (nxt_pcol >= PW'(IMG_W)) ||
                   nxt_addr[AW-1];
    end

    // Next state, issue-side registers, and the write strobes delayed one cycle to match the BRAM latency.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        odd_d       = odd_q;
        e_d         = e_q;
        base_d      = base_q;
        addr_d      = addr_q;
        issue_pad_d = issue_pad_q;
        wr_en1_d    = 1'b0;
        wr_en2_d    = 1'b0;
        wr_addr_d   = '0;
        wr_pad_d    = 1'b0;
        load_next   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (req_ok) begin
                        state_d   = S_ISSUE;
                        row_d     = i_row;
                        col_d     = i_col;
                        load_next = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ISSUE: begin
                wr_en1_d  = ~odd_q;
                wr_en2_d  = odd_q;
                wr_addr_d = e_q;
                wr_pad_d  = issue_pad_q;
                if (last_issue) begin
                    state_d = S_DRAIN;
                end else begin
                    load_next = 1'b1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (load_next) begin
            kr_d        = nxt_kr;
            kc_d        = nxt_kc;
            odd_d       = nxt_odd;
            e_d         = nxt_e;
            base_d      = nxt_base;
            issue_pad_d = nxt_oor;
            // An out-of-image pixel leaves the BRAM address where it was.
            if (!nxt_oor) begin
                addr_d = nxt_addr[BRAM_ADDR_WIDTH-1:0];
            end
        end
    end

    // State and pipeline registers, with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            odd_q       <= 1'b0;
            e_q         <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            issue_pad_q <= 1'b0;
            wr_en1_q    <= 1'b0;
            wr_en2_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_pad_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            odd_q       <= odd_d;
            e_q         <= e_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            issue_pad_q <= issue_pad_d;
            wr_en1_q    <= wr_en1_d;
            wr_en2_q    <= wr_en2_d;
            wr_addr_q   <= wr_addr_d;
            wr_pad_q    <= wr_pad_d;
        end
    end

    assign o_bram_addr = addr_q;
    assign o_wr_en1    = wr_en1_q;
    assign o_wr_en2    = wr_en2_q;
    assign o_wr_addr   = wr_addr_q;
    // Write data is BRAM data during a real write. It is 0 for a padded pixel and 0 when idle.
    assign o_wr_data   = ((wr_en1_q || wr_en2_q) && !wr_pad_q) ? i_bram_data : '0;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
`ifdef WINDOW_LOADER_ZERO_PAD_EN
    assign o_err       = 1'b0;
`else
    assign o_err       = (state_q == S_ERR);
`endif

endmodule

// File: tb/tb_window_loader.sv
// tb_window_loader: directed vectors for window_loader with a BRAM model
// returning addr[7:0] one cycle after the address is presented.
// Cycle 0 is the cycle in which i_start is sampled in IDLE.
module tb_window_loader;
    localparam int K   = 3;
    localparam int DW  = 8;
    localparam int IW  = 28;
    localparam int IH  = 28;
    localparam int CW  = 5;
    localparam int BAW = 10;
    localparam int AS  = 4;
    localparam int NE  = K * K;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [CW-1:0] row, col;
    logic [BAW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          wr_en1, wr_en2;
    logic [AS-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, done, err;

    window_loader #(
        .KERNEL_SIZE(K), .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .STRIDE(1),
        .COORD_WIDTH(CW), .BRAM_ADDR_WIDTH(BAW), .ADDR_SIZE(AS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_row(row), .i_col(col),
        .o_bram_addr(bram_addr), .i_bram_data(bram_data),
        .o_wr_en1(wr_en1), .o_wr_en2(wr_en2), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_busy(busy), .o_done(done), .o_err(err)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Image BRAM model: each pixel holds the low byte of its own address.
    always @(posedge clk) bram_data <= bram_addr[7:0];

    // ---------------- scoreboard / recorder ----------------
    int n_vec = 0;
    int n_bad = 0;
    int exp_hold = 0;

    int cyc, both_cnt, bad_addr, n_wr1, n_wr2;
    int done_cnt, done_first, done_last, err_cnt, err_first;
    int busy_cnt, busy_last, first_wr, last_wr;
    int c1[NE], c2[NE];
    logic [DW-1:0] w1[NE], w2[NE];
    bit busy_at[64], wr_at[64];

    task automatic clear_rec();
        cyc = 0; both_cnt = 0; bad_addr = 0; n_wr1 = 0; n_wr2 = 0;
        done_cnt = 0; done_first = -1; done_last = -1; err_cnt = 0; err_first = -1;
        busy_cnt = 0; busy_last = -1; first_wr = -1; last_wr = -1;
        for (int i = 0; i < NE; i++) begin
            c1[i] = 0; c2[i] = 0; w1[i] = 'x; w2[i] = 'x;
        end
        for (int i = 0; i < 64; i++) begin
            busy_at[i] = 1'b0; wr_at[i] = 1'b0;
        end
    endtask

    // Records every write and pulse once per cycle, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cyc < 64) begin
            busy_at[cyc] = busy;
            wr_at[cyc] = wr_en1 | wr_en2;
        end
        if (busy) begin busy_cnt++; busy_last = cyc; end
        if (done) begin done_cnt++; done_last = cyc; if (done_first < 0) done_first = cyc; end
        if (err) begin err_cnt++; if (err_first < 0) err_first = cyc; end
        if (wr_en1 && wr_en2) both_cnt++;
        if (wr_en1 || wr_en2) begin
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (int'(wr_addr) >= NE) bad_addr++;
            else begin
                if (wr_en1) begin c1[int'(wr_addr)]++; w1[int'(wr_addr)] = wr_data; n_wr1++; end
                if (wr_en2) begin c2[int'(wr_addr)]++; w2[int'(wr_addr)] = wr_data; n_wr2++; end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference pixel model for window w (0/1) at entry e.
    function automatic bit pix_in(input int r0, input int c0, input int w, input int e);
        int r, c;
        r = r0 + e / K;
        c = c0 + e % K + w;
        return (r < IH) && (c < IW);
    endfunction

    function automatic int pix_addr(input int r0, input int c0, input int w, input int e);
        return (r0 + e / K) * IW + c0 + e % K + w;
    endfunction

    function automatic int exp_pix(input int r0, input int c0, input int w, input int e);
        return pix_in(r0, c0, w, e) ? (pix_addr(r0, c0, w, e) % 256) : 0;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, " bram_addr"}, 32'(bram_addr), 0);
        check({tag, " wr_en1"}, 32'(wr_en1), 0);
        check({tag, " wr_en2"}, 32'(wr_en2), 0);
        check({tag, " wr_addr"}, 32'(wr_addr), 0);
        check({tag, " wr_data"}, 32'(wr_data), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " err"}, 32'(err), 0);
    endtask

    // One full request: start in cycle 0, observe through cycle 24, then score it.
    task automatic do_load(input int r, input int c, input bit exp_err, input int w2_last, input string tag);
        @(negedge clk);
        row = CW'(r); col = CW'(c); start = 1'b1;
        @(posedge clk);
        clear_rec();
        @(negedge clk);
        start = 1'b0;
        repeat (23) @(negedge clk);
        #1;
        check({tag, " both_strobes"}, both_cnt, 0);
        check({tag, " bad_wr_addr"}, bad_addr, 0);
        if (exp_err) begin
            check({tag, " err_cnt"}, err_cnt, 1);
            check({tag, " err_cycle"}, err_first, 1);
            check({tag, " done_cnt"}, done_cnt, 0);
            check({tag, " writes"}, n_wr1 + n_wr2, 0);
            check({tag, " busy_cycles"}, busy_cnt, 1);
            check({tag, " busy_last"}, busy_last, 1);
        end else begin
            check({tag, " err_cnt"}, err_cnt, 0);
            check({tag, " done_cnt"}, done_cnt, 1);
            check({tag, " done_cycle"}, done_first, 20);
            check({tag, " busy_cycles"}, busy_cnt, 20);
            check({tag, " busy_last"}, busy_last, 20);
            check({tag, " first_write"}, first_wr, 2);
            check({tag, " last_write"}, last_wr, 19);
            check({tag, " w2[8] hand"}, 32'(w2[NE-1]), w2_last);
            for (int e = 0; e < NE; e++) begin
                check($sformatf("%s w1[%0d] count", tag, e), c1[e], 1);
                check($sformatf("%s w2[%0d] count", tag, e), c2[e], 1);
                check($sformatf("%s w1[%0d] data", tag, e), 32'(w1[e]), exp_pix(r, c, 0, e));
                check($sformatf("%s w2[%0d] data", tag, e), 32'(w2[e]), exp_pix(r, c, 1, e));
            end
            for (int n = 0; n < 2 * NE; n++) begin
                if (pix_in(r, c, n % 2, n / 2)) exp_hold = pix_addr(r, c, n % 2, n / 2);
            end
        end
        check({tag, " bram_addr_hold"}, 32'(bram_addr), exp_hold);
    endtask

    typedef struct {
        int row;
        int col;
        bit exp_err;
        int exp_w2_last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Vector table: {row, col, expect rejection, hand-computed window2 entry 8}.
`ifdef WINDOW_LOADER_ZERO_PAD_EN
        vecs[0] = '{0, 0, 1'b0, 59};
        vecs[1] = '{25, 24, 1'b0, 15};
        vecs[2] = '{0, 25, 1'b0, 0};
        vecs[3] = '{26, 0, 1'b0, 0};
        vecs[4] = '{10, 5, 1'b0, 88};
        vecs[5] = '{31, 31, 1'b0, 0};
        vecs[6] = '{25, 25, 1'b0, 0};
`else
        vecs[0] = '{0, 0, 1'b0, 59};
        vecs[1] = '{25, 24, 1'b0, 15};
        vecs[2] = '{0, 25, 1'b1, 0};
        vecs[3] = '{26, 0, 1'b1, 0};
        vecs[4] = '{10, 5, 1'b0, 88};
        vecs[5] = '{31, 31, 1'b1, 0};
        vecs[6] = '{25, 25, 1'b1, 0};
`endif
        clear_rec();
        rst = 1'b1; start = 1'b0; row = '0; col = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        exp_hold = 0;

        // Table-driven loads.
        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].row, vecs[i].col, vecs[i].exp_err, vecs[i].exp_w2_last,
                    $sformatf("vec%0d", i));
        end

        // i_start held high: the second load may only begin from IDLE in cycle 21.
        @(negedge clk);
        row = '0; col = '0; start = 1'b1;
        @(posedge clk);
        clear_rec();
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("hold done_cnt", done_cnt, 2);
        check("hold done_first", done_first, 20);
        check("hold done_last", done_last, 41);
        check("hold busy_c21", 32'(busy_at[21]), 0);
        check("hold busy_c22", 32'(busy_at[22]), 1);
        check("hold busy_c42", 32'(busy_at[42]), 0);
        check("hold busy_cycles", busy_cnt, 40);
        check("hold wr_c20", 32'(wr_at[20]), 0);
        check("hold wr_c21", 32'(wr_at[21]), 0);
        check("hold wr_c22", 32'(wr_at[22]), 0);
        check("hold wr_c23", 32'(wr_at[23]), 1);
        check("hold n_wr1", n_wr1, 2 * NE);
        check("hold n_wr2", n_wr2, 2 * NE);
        check("hold both_strobes", both_cnt, 0);
        check("hold w2[8]", 32'(w2[NE-1]), 59);
        exp_hold = 59;

        // Reset in cycle 10, mid-ISSUE.
        @(negedge clk);
        row = CW'(10); col = CW'(5); start = 1'b1;
        @(posedge clk);
        clear_rec();
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst busy_before", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_outputs_zero("midrst c11");
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("midrst done_cnt", done_cnt, 0);
        check("midrst busy_after", 32'(busy), 0);
        exp_hold = 0;
        do_load(10, 5, 1'b0, 88, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
